// File: rtl/fp32_add_unit.sv
// Multi-cycle binary32 adder/subtractor with a round-to-nearest-even rounding mode.
// Subnormal operands read as zero, and subnormal results flush to zero.
module fp32_add_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sub_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N-1:0] result_o,
  output logic [3:0]   flags_o
);

  if (N != 32) begin : g_bad_width
    $error("fp32_add_unit supports only N = 32");
  end

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      a_q, a_d, b_q, b_d;
  logic              sub_q, sub_d;
  logic              sign_q, sign_d;
  logic              zneg_q, zneg_d;
  logic              esub_q, esub_d;
  logic [7:0]        ex_q, ex_d;
  logic [26:0]       mx_q, mx_d, my_q, my_d;
  logic              spec_q, spec_d;
  logic [31:0]       spec_res_q, spec_res_d;
  logic [3:0]        spec_flags_q, spec_flags_d;
  logic [27:0]       sum_q, sum_d;
  logic signed [9:0] nexp_q, nexp_d;
  logic [26:0]       nsig_q, nsig_d;
  logic              nzero_q, nzero_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       result_q, result_d;
  logic [3:0]        flags_q, flags_d;

  logic        sa, sb, za, zb, a_nan, b_nan, a_inf, b_inf, swap;
  logic        spec_hit;
  logic [31:0] spec_val;
  logic [3:0]  spec_flg;
  logic [7:0]  ea, eb, diff;
  logic [26:0] siga, sigb, sigy, shifted, lost_mask, aligned_y;

  // Magnitude keys zero the subnormals so the swap compares DAZ values.
  always_comb begin
    ea        = a_q[30:23];
    eb        = b_q[30:23];
    sa        = a_q[31];
    sb        = b_q[31] ^ sub_q;
    za        = (ea == 8'd0);
    zb        = (eb == 8'd0);
    a_nan     = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
    b_nan     = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
    a_inf     = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
    b_inf     = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
    siga      = za ? 27'd0 : {1'b1, a_q[22:0], 3'b000};
    sigb      = zb ? 27'd0 : {1'b1, b_q[22:0], 3'b000};
    swap      = (zb ? 31'd0 : b_q[30:0]) > (za ? 31'd0 : a_q[30:0]);
    diff      = swap ? (eb - ea) : (ea - eb);
    sigy      = swap ? siga : sigb;
    lost_mask = (27'd1 << diff) - 27'd1;
    shifted   = sigy >> diff;
    if (diff >= 8'd27)
      aligned_y = {26'd0, |sigy};
    else
      aligned_y = {shifted[26:1], shifted[0] | (|(sigy & lost_mask))};

    spec_hit = 1'b1;
    spec_val = 32'h7FC00000;
    spec_flg = 4'b0000;
    if (a_nan || b_nan)
      spec_flg = {(a_nan && !a_q[22]) || (b_nan && !b_q[22]), 3'b000};
    else if (a_inf && b_inf && (sa != sb))
      spec_flg = 4'b1000;
    else if (a_inf)
      spec_val = {sa, 8'hFF, 23'd0};
    else if (b_inf)
      spec_val = {sb, 8'hFF, 23'd0};
    else
      spec_hit = 1'b0;
  end

  logic [4:0] lzc;

  always_comb begin
    lzc = 5'd27;
    for (int i = 0; i < 27; i++)
      if (sum_q[i]) lzc = 5'(26 - i);
  end

  logic              rinc, nx;
  logic [24:0]       rmant;
  logic signed [9:0] rexp;

  always_comb begin
    nx    = |nsig_q[2:0];
    rinc  = nsig_q[2] & (nsig_q[1] | nsig_q[0] | nsig_q[3]);
    rmant = {1'b0, nsig_q[26:3]} + {24'd0, rinc};
    rexp  = nexp_q + (rmant[24] ? 10'sd1 : 10'sd0);
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    sub_d        = sub_q;
    sign_d       = sign_q;
    zneg_d       = zneg_q;
    esub_d       = esub_q;
    ex_d         = ex_q;
    mx_d         = mx_q;
    my_d         = my_q;
    spec_d       = spec_q;
    spec_res_d   = spec_res_q;
    spec_flags_d = spec_flags_q;
    sum_d        = sum_q;
    nexp_d       = nexp_q;
    nsig_d       = nsig_q;
    nzero_d      = nzero_q;
    out_valid_d  = out_valid_q;
    result_d     = result_q;
    flags_d      = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          sub_d   = sub_i;
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        sign_d       = swap ? sb : sa;
        zneg_d       = sa & sb & za & zb;
        esub_d       = sa ^ sb;
        ex_d         = swap ? eb : ea;
        mx_d         = swap ? sigb : siga;
        my_d         = aligned_y;
        spec_d       = spec_hit;
        spec_res_d   = spec_val;
        spec_flags_d = spec_flg;
        state_d      = ADD;
      end
      ADD: begin
        sum_d   = esub_q ? ({1'b0, mx_q} - {1'b0, my_q}) : ({1'b0, mx_q} + {1'b0, my_q});
        state_d = NORM;
      end
      NORM: begin
        nzero_d = (sum_q == 28'd0);
        if (sum_q[27]) begin
          nsig_d = {sum_q[27:2], sum_q[1] | sum_q[0]};
          nexp_d = $signed({2'b00, ex_q}) + 10'sd1;
        end else begin
          nsig_d = sum_q[26:0] << lzc;
          nexp_d = $signed({2'b00, ex_q}) - $signed({5'd0, lzc});
        end
        state_d = ROUND;
      end
      ROUND: begin
        out_valid_d = 1'b1;
        state_d     = DONE;
        if (spec_q) begin
          result_d = spec_res_q;
          flags_d  = spec_flags_q;
        end else if (nzero_q) begin
          result_d = {zneg_q, 31'd0};
          flags_d  = 4'b0000;
        end else if (nexp_q <= 10'sd0) begin
          result_d = {sign_q, 31'd0};
          flags_d  = 4'b0011;
        end else if (rexp >= 10'sd255) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          flags_d  = 4'b0101;
        end else begin
          result_d = {sign_q, rexp[7:0], rmant[24] ? rmant[23:1] : rmant[22:0]};
          flags_d  = {3'b000, nx};
        end
      end
      DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          result_d    = 32'd0;
          flags_d     = 4'b0000;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      sub_q        <= 1'b0;
      sign_q       <= 1'b0;
      zneg_q       <= 1'b0;
      esub_q       <= 1'b0;
      ex_q         <= 8'd0;
      mx_q         <= 27'd0;
      my_q         <= 27'd0;
      spec_q       <= 1'b0;
      spec_res_q   <= 32'd0;
      spec_flags_q <= 4'd0;
      sum_q        <= 28'd0;
      nexp_q       <= 10'sd0;
      nsig_q       <= 27'd0;
      nzero_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      result_q     <= 32'd0;
      flags_q      <= 4'd0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sub_q        <= sub_d;
      sign_q       <= sign_d;
      zneg_q       <= zneg_d;
      esub_q       <= esub_d;
      ex_q         <= ex_d;
      mx_q         <= mx_d;
      my_q         <= my_d;
      spec_q       <= spec_d;
      spec_res_q   <= spec_res_d;
      spec_flags_q <= spec_flags_d;
      sum_q        <= sum_d;
      nexp_q       <= nexp_d;
      nsig_q       <= nsig_d;
      nzero_q      <= nzero_d;
      out_valid_q  <= out_valid_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE) && !rst;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign flags_o     = flags_q;

endmodule

// File: tb/tb_fp32_add_unit.sv
// Bench for fp32_add_unit: directed vectors with literal expectations, plus an
// exact-arithmetic reference model checked against the outputs on every cycle.
module tb_fp32_add_unit;

  logic        clk = 1'b0;
  logic        rst, inValid, inReady, sub, outValid, outReady;
  logic [31:0] opA, opB, result;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
  } expect_t;

  expect_t expQ[$];

  always #5 clk = ~clk;

  fp32_add_unit #(.N(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (inValid),
    .in_ready_o (inReady),
    .a_i        (opA),
    .b_i        (opB),
    .sub_i      (sub),
    .out_valid_o(outValid),
    .out_ready_i(outReady),
    .result_o   (result),
    .flags_o    (flags)
  );

  task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Exact sum on a wide integer grid (unit 2^-149), then a single RNE rounding.
  function automatic expect_t modelAdd(logic [31:0] a, logic [31:0] b, logic s);
    expect_t      r;
    logic         sa, sb, sign, aNan, bNan, aInf, bInf, nx;
    logic [299:0] va, vb, mag, keep, rem, half;
    int           ea, eb, p, e, sh;
    sa   = a[31];
    sb   = b[31] ^ s;
    ea   = int'(a[30:23]);
    eb   = int'(b[30:23]);
    aNan = (ea == 255) && (a[22:0] != 23'd0);
    bNan = (eb == 255) && (b[22:0] != 23'd0);
    aInf = (ea == 255) && (a[22:0] == 23'd0);
    bInf = (eb == 255) && (b[22:0] == 23'd0);
    r.res   = 32'h7FC00000;
    r.flags = 4'b0000;
    if (aNan || bNan) begin
      r.flags = {(aNan && !a[22]) || (bNan && !b[22]), 3'b000};
      return r;
    end
    if (aInf && bInf && (sa != sb)) begin
      r.flags = 4'b1000;
      return r;
    end
    if (aInf) begin r.res = {sa, 8'hFF, 23'd0}; return r; end
    if (bInf) begin r.res = {sb, 8'hFF, 23'd0}; return r; end
    va = (ea == 0) ? 300'd0 : (300'({1'b1, a[22:0]}) << (ea - 1));
    vb = (eb == 0) ? 300'd0 : (300'({1'b1, b[22:0]}) << (eb - 1));
    if (sa == sb) begin mag = va + vb; sign = sa; end
    else if (va >= vb) begin mag = va - vb; sign = sa; end
    else begin mag = vb - va; sign = sb; end
    if (mag == 300'd0) begin
      r.res = {sa & sb, 31'd0};
      return r;
    end
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p - 22;
    if (e <= 0) begin
      r.res   = {sign, 31'd0};
      r.flags = 4'b0011;
      return r;
    end
    sh   = p - 23;
    keep = mag >> sh;
    rem  = mag - (keep << sh);
    half = (sh == 0) ? 300'd0 : (300'd1 << (sh - 1));
    nx   = (rem != 300'd0);
    if (sh > 0 && ((rem > half) || (rem == half && keep[0]))) keep = keep + 300'd1;
    if (keep[24]) begin keep = keep >> 1; e++; end
    if (e >= 255) begin
      r.res   = {sign, 8'hFF, 23'd0};
      r.flags = 4'b0101;
      return r;
    end
    r.res   = {sign, e[7:0], keep[22:0]};
    r.flags = {3'b000, nx};
    return r;
  endfunction

  // Whenever the output is valid it must match the model's oldest pending result.
  always @(negedge clk) begin
    if (!rst) begin
      if (outValid) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got result %h, expected no output", result);
        end else begin
          check("model_result", result, expQ[0].res);
          check("model_flags", 32'(flags), 32'(expQ[0].flags));
        end
      end else begin
        check("idle_flags", 32'(flags), 32'd0);
      end
    end
  end

  task automatic applyStimulus(logic [31:0] a, logic [31:0] b, logic s);
    check("in_ready_before_accept", 32'(inReady), 32'd1);
    opA     = a;
    opB     = b;
    sub     = s;
    inValid = 1'b1;
    expQ.push_back(modelAdd(a, b, s));
    @(negedge clk);
    inValid = 1'b0;
    check("in_ready_busy", 32'(inReady), 32'd0);
  endtask

  task automatic waitResult(string name);
    int cycles = 0;
    while (!outValid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    check({name, "_latency"}, 32'(cycles), 32'd4);
  endtask

  task automatic checkOutput(string name, logic [31:0] expRes, logic [3:0] expFlags);
    check({name, "_valid"}, 32'(outValid), 32'd1);
    check({name, "_result"}, result, expRes);
    check({name, "_flags"}, 32'(flags), 32'(expFlags));
    check({name, "_in_ready_held"}, 32'(inReady), 32'd0);
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    check({name, "_valid_cleared"}, 32'(outValid), 32'd0);
    check({name, "_in_ready_back"}, 32'(inReady), 32'd1);
    if (expQ.size() > 0) void'(expQ.pop_front());
  endtask

  task automatic runVector(string name, logic [31:0] a, logic [31:0] b, logic s,
                           logic [31:0] expRes, logic [3:0] expFlags);
    applyStimulus(a, b, s);
    waitResult(name);
    checkOutput(name, expRes, expFlags);
  endtask

  initial begin
    rst      = 1'b1;
    inValid  = 1'b0;
    opA      = 32'd0;
    opB      = 32'd0;
    sub      = 1'b0;
    outReady = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", 32'(outValid), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_flags", 32'(flags), 32'd0);
    check("reset_in_ready", 32'(inReady), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("release_in_ready", 32'(inReady), 32'd1);

    runVector("add_1_2",        32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    runVector("cancel",         32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
    runVector("neg_zeros",      32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
    runVector("mixed_zeros",    32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000);
    runVector("daz_input",      32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000);
    runVector("tie_even",       32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
    runVector("above_tie",      32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001);
    runVector("tie_odd_up",     32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);
    runVector("guard_round",    32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001);
    runVector("exact_below_1",  32'h3F800000, 32'hB3800000, 1'b0, 32'h3F7FFFFF, 4'b0000);
    runVector("far_sticky",     32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0001);
    runVector("sub_3_1",        32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);
    runVector("sub_1_2",        32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000);
    runVector("overflow",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
    runVector("round_overflow", 32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 4'b0101);
    runVector("inf_minus_inf",  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000);
    runVector("snan_input",     32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
    runVector("qnan_input",     32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000);
    runVector("neg_inf_finite", 32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 4'b0000);
    runVector("finite_sub_inf", 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000);
    runVector("underflow",      32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011);

    applyStimulus(32'h3F800000, 32'h40000000, 1'b0);
    waitResult("backpressure");
    for (int i = 0; i < 10; i++) begin
      check("bp_valid_held", 32'(outValid), 32'd1);
      check("bp_result_stable", result, 32'h40400000);
      check("bp_flags_stable", 32'(flags), 32'd0);
      check("bp_in_ready_low", 32'(inReady), 32'd0);
      if (i == 3) begin
        opA     = 32'h40000000;
        opB     = 32'h40000000;
        inValid = 1'b1;
      end else begin
        inValid = 1'b0;
      end
      @(negedge clk);
    end
    inValid = 1'b0;
    checkOutput("bp_release", 32'h40400000, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      check("bp_no_ghost_output", 32'(outValid), 32'd0);
      @(negedge clk);
    end

    applyStimulus(32'h40400000, 32'h3F800000, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_norm_out_valid", 32'(outValid), 32'd0);
    check("rst_norm_in_ready", 32'(inReady), 32'd0);
    expQ.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rst_no_stale_output", 32'(outValid), 32'd0);
    end
    runVector("after_reset", 32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 4'b0000);

    applyStimulus(32'h3F800000, 32'h3F800000, 1'b0);
    waitResult("rst_done");
    rst = 1'b1;
    #1;
    check("rst_done_out_valid", 32'(outValid), 32'd0);
    check("rst_done_result", result, 32'd0);
    check("rst_done_flags", 32'(flags), 32'd0);
    expQ.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_done_in_ready", 32'(inReady), 32'd1);
    runVector("after_rst_done", 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
